paridade_stream: RTL and testbench

Sequential, parametrised successor to the combinational `paridade` block. It accepts a stream of WIDTH-bit words with a valid/ready handshake and frame delimiting. It accumulates parity across every word of a frame and emits one registered frame result: frame parity, word count, and mismatch flag against an expected parity bit. It sits between a byte-stream source and the link-integrity logic, and also provides per-word parity combinationally for reuse.

---
 rtl/paridade_pkg.sv | 30 +++
 rtl/paridade_stream_if.sv | 49 ++++
 rtl/paridade.sv | 15 +
 rtl/paridade_stream.sv | 159 +++++++++++++++
 tb/tb_paridade_stream.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paridade_pkg.sv
// -----------------------------------------------------------------------------
// paridade_pkg
// Shared definitions for the paridade stream parity block.
//   - State encoding of the frame FSM (IDLE / ACC / HOLD).
//   - Parity-mode constants (even / odd).
//   - frame_parity(): applies the frame's parity mode to the raw XOR reduction.
// -----------------------------------------------------------------------------
package paridade_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;  // no frame open
    localparam logic [1:0] ST_ACC  = 2'd1;  // frame open, accumulating
    localparam logic [1:0] ST_HOLD = 2'd2;  // result pending downstream

    // Parity modes
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ACC  = ST_ACC,
        S_HOLD = ST_HOLD
    } state_e;

    // Odd parity is the complement of the even-sense XOR reduction.
    function automatic logic frame_parity(input logic acc, input logic mode);
        return (mode == PAR_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/paridade_stream_if.sv
// -----------------------------------------------------------------------------
// paridade_stream_if
// Bundles the input beat stream, the frame-result stream and the status
// outputs of paridade_stream.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid && ready are both 1. A source holding valid=1 keeps its
// payload stable until the transfer. ready may depend on the sink's state but
// never on valid of the same stream.
//
// Signals:
//   in_valid/in_ready/in_data/in_last/in_odd/in_chk/in_exp : input beats
//   word_par                                                : ^in_data (even)
//   out_valid/out_ready/out_par/out_cnt/out_ovf/out_err     : frame result
//   err_cnt                                                 : errored frames
// Modports: master = stream source / result sink, slave = paridade_stream.
// -----------------------------------------------------------------------------
interface paridade_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_odd;
    logic             in_chk;
    logic             in_exp;
    logic             word_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_par;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_data, in_last, in_odd, in_chk, in_exp, out_ready,
        input  in_ready, word_par, out_valid, out_par, out_cnt, out_ovf,
               out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, in_odd, in_chk, in_exp, out_ready,
        output in_ready, word_par, out_valid, out_par, out_cnt, out_ovf,
               out_err, err_cnt
    );
endinterface

// File: rtl/paridade.sv
// -----------------------------------------------------------------------------
// paridade
// Combinational even-sense parity of one word.
// Ports:
//   data : WIDTH-bit word
//   par  : XOR reduction of data (1 when data has an odd number of ones)
// -----------------------------------------------------------------------------
module paridade #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             par
);
    assign par = ^data;
endmodule

// File: rtl/paridade_stream.sv
// -----------------------------------------------------------------------------
// paridade_stream
// Accumulates parity over every word of a frame and presents one registered
// result per frame: parity (even/odd mode latched on the first beat), word
// count (saturating, with overflow flag) and a mismatch flag against an
// expected parity bit. Also counts errored frames since reset.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, priority over all handshakes
//   bus       : paridade_stream_if slave (input beats, results, status)
//   dbg_state : current FSM state (ST_IDLE / ST_ACC / ST_HOLD)
// -----------------------------------------------------------------------------
module paridade_stream
    import paridade_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    paridade_stream_if.slave       bus,
    output logic [1:0]             dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             out_par_q, out_par_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             wp;
    logic             in_ready;
    logic             accept;
    logic             start;     // accepted beat opens a new frame
    logic             step;      // accepted beat extends the open frame
    logic             f_acc;     // frame state including the current beat
    logic             f_mode;
    logic             f_ovf;
    logic [CNT_W-1:0] f_cnt;
    logic             f_par;
    logic             f_err;

    paridade #(.WIDTH(WIDTH)) u_par (
        .data (bus.in_data),
        .par  (wp)
    );

    // Only a pending, unconsumed result stalls the input.
    assign in_ready = (state_q != S_HOLD) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        start = 1'b0;
        step  = 1'b0;
        case (state_q)
            S_IDLE:  start = accept;
            S_ACC:   step  = accept;
            // accept in HOLD implies out_ready: result leaves, new frame opens
            S_HOLD:  start = accept;
            default: start = 1'b0;
        endcase

        if (start) begin
            f_acc  = wp;
            f_cnt  = CNT_ONE;
            f_ovf  = 1'b0;
            f_mode = bus.in_odd;
        end else begin
            f_acc  = acc_q ^ wp;
            f_mode = mode_q;
            if (&cnt_q) begin
                f_cnt = cnt_q;
                f_ovf = 1'b1;
            end else begin
                f_cnt = cnt_q + CNT_ONE;
                f_ovf = ovf_q;
            end
        end

        f_par = frame_parity(f_acc, f_mode);
        f_err = bus.in_chk && (f_par != bus.in_exp);

        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        out_par_d = out_par_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        out_err_d = out_err_q;
        err_cnt_d = err_cnt_q;

        if (start || step) begin
            acc_d  = f_acc;
            cnt_d  = f_cnt;
            ovf_d  = f_ovf;
            mode_d = f_mode;
            if (bus.in_last) begin
                state_d   = S_HOLD;
                out_par_d = f_par;
                out_cnt_d = f_cnt;
                out_ovf_d = f_ovf;
                out_err_d = f_err;
                if (f_err && !(&err_cnt_q)) begin
                    err_cnt_d = err_cnt_q + CNT_ONE;
                end
            end else begin
                state_d = S_ACC;
            end
        end else if (state_q == S_HOLD && bus.out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= PAR_EVEN;
            ovf_q     <= 1'b0;
            out_par_q <= 1'b0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
            out_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            out_par_q <= out_par_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.word_par  = wp;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_par   = out_par_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_paridade_stream.sv
// -----------------------------------------------------------------------------
// tb_paridade_stream
// Directed bench for paridade_stream: an 8-bit-counter instance for framing,
// modes, backpressure and mid-frame reset, and a 2-bit-counter instance for
// count/error saturation.
// -----------------------------------------------------------------------------
module tb_paridade_stream;
    import paridade_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    paridade_stream_if #(.WIDTH(8), .CNT_W(8)) bus8();
    paridade_stream_if #(.WIDTH(8), .CNT_W(2)) bus2();
    logic [1:0] dbg8;
    logic [1:0] dbg2;

    paridade_stream #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus8),
        .dbg_state (dbg8)
    );

    paridade_stream #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .dbg_state (dbg2)
    );

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard (dut8 results) ----------------
    // {par, cnt[7:0], ovf, err, err_cnt[7:0]}
    logic [18:0] exp_q[$];
    logic [18:0] sb_exp;

    function automatic logic [18:0] pack_res(input logic p, input logic [7:0] c,
                                             input logic o, input logic e,
                                             input logic [7:0] ec);
        return {p, c, o, e, ec};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: result 0x%0h with no expected entry at %0t",
                         pack_res(bus8.out_par, bus8.out_cnt, bus8.out_ovf, bus8.out_err,
                                  bus8.err_cnt), $time);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_result",
                      32'(pack_res(bus8.out_par, bus8.out_cnt, bus8.out_ovf, bus8.out_err,
                                   bus8.err_cnt)),
                      32'(sb_exp));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       odd;
        logic       chk;
        logic       ex;
        logic       e_par;
        logic [7:0] e_cnt;
        logic       e_ovf;
        logic       e_err;
        logic [7:0] e_errcnt;
    } vec_t;

    vec_t tbl[17];

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
    task automatic beat8(input logic [7:0] d, input logic last, input logic odd,
                         input logic chk, input logic ex);
        logic took;
        took = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.in_data  = d;
        bus8.in_last  = last;
        bus8.in_odd   = odd;
        bus8.in_chk   = chk;
        bus8.in_exp   = ex;
        for (int t = 0; t < 16 && !took; t++) begin
            @(negedge clk);
            took = bus8.in_ready;
            @(posedge clk);
            #1;
        end
        bus8.in_valid = 1'b0;
        check("beat8_accept", {31'd0, took}, 32'd1);
    endtask

    task automatic beat2(input logic [7:0] d, input logic last, input logic odd,
                         input logic chk, input logic ex);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_last  = last;
        bus2.in_odd   = odd;
        bus2.in_chk   = chk;
        bus2.in_exp   = ex;
        @(negedge clk);
        check("beat2_ready", {31'd0, bus2.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    task automatic res2(input logic p, input logic [1:0] c, input logic o,
                        input logic e, input logic [1:0] ec);
        @(negedge clk);
        check("b2_valid", {31'd0, bus2.out_valid}, 32'd1);
        check("b2_par",   {31'd0, bus2.out_par},   {31'd0, p});
        check("b2_cnt",   {30'd0, bus2.out_cnt},   {30'd0, c});
        check("b2_ovf",   {31'd0, bus2.out_ovf},   {31'd0, o});
        check("b2_err",   {31'd0, bus2.out_err},   {31'd0, e});
        check("b2_errcnt",{30'd0, bus2.err_cnt},   {30'd0, ec});
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //            data   l     odd   chk   ex    par   cnt   ovf   err   errcnt
        tbl[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{8'h82, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 8'd1};
        tbl[4]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 8'd1};
        // mode from first beat only, chk/exp from last beat only
        tbl[5]  = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 8'd2};
        // streaming one-word frames
        tbl[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[8]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[9]  = '{8'h82, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[10] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[11] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[12] = '{8'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[13] = '{8'h71, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[14] = '{8'hE3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[15] = '{8'h8A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 8'd2};
        tbl[16] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 8'd2};

        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0;
        bus8.in_odd = 1'b0; bus8.in_chk = 1'b0; bus8.in_exp = 1'b0; bus8.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
        bus2.in_odd = 1'b0; bus2.in_chk = 1'b0; bus2.in_exp = 1'b0; bus2.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid",   {31'd0, bus8.out_valid}, 32'd0);
        check("rst_par",     {31'd0, bus8.out_par},   32'd0);
        check("rst_cnt",     {24'd0, bus8.out_cnt},   32'd0);
        check("rst_ovf",     {31'd0, bus8.out_ovf},   32'd0);
        check("rst_err",     {31'd0, bus8.out_err},   32'd0);
        check("rst_errcnt",  {24'd0, bus8.err_cnt},   32'd0);
        check("rst_ready",   {31'd0, bus8.in_ready},  32'd1);
        check("rst_state",   {30'd0, dbg8},           {30'd0, ST_IDLE});
        check("rst_valid2",  {31'd0, bus2.out_valid}, 32'd0);
        check("rst_errcnt2", {30'd0, bus2.err_cnt},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- table: frames, modes, checks, streaming ----
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_data  = tbl[i].data;
            bus8.in_last  = tbl[i].last;
            bus8.in_odd   = tbl[i].odd;
            bus8.in_chk   = tbl[i].chk;
            bus8.in_exp   = tbl[i].ex;
            if (tbl[i].last)
                exp_q.push_back(pack_res(tbl[i].e_par, tbl[i].e_cnt, tbl[i].e_ovf,
                                         tbl[i].e_err, tbl[i].e_errcnt));
            @(negedge clk);
            check("word_par",  {31'd0, bus8.word_par},  {31'd0, ^tbl[i].data});
            check("in_ready",  {31'd0, bus8.in_ready},  32'd1);
            check("valid_lat", {31'd0, bus8.out_valid},
                  {31'd0, (i > 0) ? tbl[i-1].last : 1'b0});
            @(posedge clk);
            #1;
        end
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("valid_lat", {31'd0, bus8.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_valid", {31'd0, bus8.out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // ---- backpressure ----
        bus8.out_ready = 1'b0;
        exp_q.push_back(pack_res(1'b1, 8'd1, 1'b0, 1'b0, 8'd2));
        beat8(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h01;
        bus8.in_last  = 1'b1;
        bus8.in_odd   = 1'b0;
        bus8.in_chk   = 1'b0;
        bus8.in_exp   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus8.out_valid}, 32'd1);
            check("bp_ready", {31'd0, bus8.in_ready},  32'd0);
            check("bp_par",   {31'd0, bus8.out_par},   32'd1);
            check("bp_cnt",   {24'd0, bus8.out_cnt},   32'd1);
            check("bp_state", {30'd0, dbg8},           {30'd0, ST_HOLD});
            @(posedge clk);
            #1;
        end
        bus8.out_ready = 1'b1;
        exp_q.push_back(pack_res(1'b1, 8'd1, 1'b0, 1'b0, 8'd2));
        @(negedge clk);
        check("bp_release_ready", {31'd0, bus8.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", {31'd0, bus8.out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // ---- mid-frame reset ----
        beat8(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        beat8(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mr_valid",  {31'd0, bus8.out_valid}, 32'd0);
        check("mr_par",    {31'd0, bus8.out_par},   32'd0);
        check("mr_cnt",    {24'd0, bus8.out_cnt},   32'd0);
        check("mr_ovf",    {31'd0, bus8.out_ovf},   32'd0);
        check("mr_err",    {31'd0, bus8.out_err},   32'd0);
        check("mr_errcnt", {24'd0, bus8.err_cnt},   32'd0);
        check("mr_state",  {30'd0, dbg8},           {30'd0, ST_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(pack_res(1'b1, 8'd1, 1'b0, 1'b0, 8'd0));
        beat8(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("mr_next_valid", {31'd0, bus8.out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // ---- saturation (CNT_W = 2) ----
        bus2.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) beat2(8'h01, k == 4, 1'b0, 1'b0, 1'b0);
        res2(1'b1, 2'd3, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) beat2(8'h01, k == 3, 1'b0, 1'b0, 1'b0);
        res2(1'b0, 2'd3, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) beat2(8'h01, k == 2, 1'b0, 1'b0, 1'b0);
        res2(1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            beat2(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
            res2(1'b0, 2'd1, 1'b0, 1'b1, (k < 3) ? 2'(k + 1) : 2'd3);
        end

        @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
